dec_scan_seq: RTL

- Upstream sequencer for the polarity-selectable 2-to-4 decoder (dec2to4_pol).
- Steps through the enabled decoder channels in ascending index order and drives the decoder's A2/A1/A0 inputs.
- Holds each channel for a programmable dwell time.
- Reports progress through a start/busy/done handshake, so downstream strobes or row drivers can be scanned without CPU involvement.

---
 rtl/dec_pkg.sv | 18 +
 rtl/dec_next_ch.sv | 29 ++
 rtl/dec_scan_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared definitions for the decoder scan sequencer.
//   state_t  : sequencer state encoding
//   NUM_CH   : number of decoder channels
//   CH_W     : width of a channel index
//   POL_HIGH : polarity value for active-high decoder outputs
package dec_pkg;

    localparam int   NUM_CH   = 4;
    localparam int   CH_W     = 2;
    localparam logic POL_HIGH = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/dec_next_ch.sv
// Combinational channel picker for the scan sequencer.
//   mask  [NUM_CH-1:0] in  : enabled channels
//   cur   [CH_W-1:0]   in  : current channel index (ignored when first=1)
//   first              in  : 1 = pick lowest set bit, 0 = lowest set bit above cur
//   nxt   [CH_W-1:0]   out : selected channel index (0 when none found)
//   found              out : a qualifying channel exists
module dec_next_ch
    import dec_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              first,
    output logic [CH_W-1:0]   nxt,
    output logic              found
);

    // Walk from the top down so the last hit written is the lowest qualifying index.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt   = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dec_scan_seq.sv
// Scan sequencer driving the A2/A1/A0 inputs of the polarity-selectable
// 2-to-4 decoder. Visits enabled channels in ascending order, holding each
// for dwell+1 cycles, with a start/busy/done handshake.
//   clk       in  : system clock, rising edge
//   rst_n     in  : asynchronous active-low reset
//   start     in  : scan request, sampled only in IDLE
//   stop      in  : abort, highest priority after reset
//   polarity  in  : decoder polarity, latched at start
//   en_mask   in  : channel enables, latched at start
//   dwell     in  : per-channel hold count, latched at start
//   A2        out : latched polarity
//   A1, A0    out : channel select
//   ch_valid  out : {A1,A0} is an active scan channel
//   busy      out : scan in progress
//   done      out : one-cycle pulse on normal completion
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for start, select parked at 00
// SCAN  | holding current channel, dwell counter running down
// FIN   | single done cycle, then back to IDLE
module dec_scan_seq
    import dec_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               polarity,
    input  logic [NUM_CH-1:0]  en_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               A2,
    output logic               A1,
    output logic               A0,
    output logic               ch_valid,
    output logic               busy,
    output logic               done
);

    state_t               state_q, state_d;
    logic                 a2_q, a2_d;
    logic [CH_W-1:0]      sel_q, sel_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;

    logic [NUM_CH-1:0]    nc_mask;
    logic                 nc_first;
    logic [CH_W-1:0]      nc_ch;
    logic                 nc_found;

    // In IDLE the picker looks at the live mask to choose the first channel;
    // during a scan it advances over the latched mask.
    assign nc_first = (state_q == IDLE);
    assign nc_mask  = nc_first ? en_mask : mask_q;

    dec_next_ch u_next_ch (
        .mask  (nc_mask),
        .cur   (sel_q),
        .first (nc_first),
        .nxt   (nc_ch),
        .found (nc_found)
    );

    always_comb begin
        state_d = state_q;
        a2_d    = a2_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                sel_d   = '0;
                if (start && !stop) begin
                    a2_d   = polarity;
                    busy_d = 1'b1;
                    if (en_mask != '0) begin
                        mask_d  = en_mask;
                        dwell_d = dwell;
                        cnt_d   = dwell;
                        sel_d   = nc_ch;
                        valid_d = 1'b1;
                        state_d = SCAN;
                    end else begin
                        // Nothing enabled: report an empty scan straight away.
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end

            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    sel_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (nc_found) begin
                    sel_d = nc_ch;
                    cnt_d = dwell_q;
                end else begin
                    state_d = FIN;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                    sel_d   = '0;
                end
            end

            FIN: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                sel_d   = '0;
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a2_q    <= POL_HIGH;
            sel_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mask_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            a2_q    <= a2_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
        end
    end

    assign A2       = a2_q;
    assign A1       = sel_q[1];
    assign A0       = sel_q[0];
    assign ch_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
